// File: rtl/mem_image_loader_pkg.sv
// Shared definitions for the memory image loader.
//   parse_state_e : input-stream parser states
//   wr_state_e    : memory-side writer states
//   MODE_PAIR / MODE_BURST : values of the 'mode' input sampled on start
package loader_defs;

    localparam logic MODE_PAIR  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCnt,
        StData,
        StDrain
    } parse_state_e;

    typedef enum logic [1:0] {
        WIdle,
        WReq,
        WVfy
    } wr_state_e;

endpackage

// File: rtl/mem_image_loader_fifo.sv
// loader_fifo: synchronous FIFO holding {addr, data} write pairs.
// Ports:
//   clk, rst       clock, synchronous active-high reset (empties the FIFO)
//   push, wdata    write side; a push while full is only taken together with a pop
//   pop, rdata     read side; rdata shows the head entry (or wdata when empty)
//   full, empty    occupancy flags
// A simultaneous push and pop is legal on a full or empty FIFO and leaves the count
// unchanged; on an empty FIFO the pushed word passes straight through to rdata.
module loader_fifo
    import loader_defs::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PtrW:0]    wptr_q, wptr_d;
    logic [PtrW:0]    rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic bypass;
    logic do_push;
    logic do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                     (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

    assign bypass  = empty & push & pop;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop) & ~bypass;

    assign rdata   = empty ? wdata : mem_q[rptr_q[PtrW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + (PtrW + 1)'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[PtrW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mem_image_loader.sv
// mem_image_loader: streams an address/data image from a host word stream into a
// memory write port. Pair mode takes (addr, data) word pairs; burst mode takes
// (addr, count, data x count) with the address incrementing modulo 2^ADDR_W and a
// count of 0 meaning 2^DATA_W bytes.
// Ports:
//   clk, rst                 clock, synchronous active-high reset (aborts a load)
//   start, mode              begin a load (ignored while busy); mode sampled on start
//   in_valid/in_ready        input word handshake; in_word, in_last qualify the word
//   mem_wr_req/mem_wr_ack    write port; mem_addr/mem_wdata held while req is high
//   mem_rd_req/mem_rd_ack    verify read port; mem_rdata compared to the written byte
//   busy, done               load in progress; one-cycle completion pulse
//   err                      sticky until next start: truncated image / verify miss
//   wr_count                 bytes written this load, saturating
// Build option: define READBACK_VERIFY_EN to read back every written byte before the
// next write; without it the read port is unused and mem_rd_req stays 0.
module mem_image_loader
    import loader_defs::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_word,
    input  logic              in_last,
    output logic              mem_wr_req,
    input  logic              mem_wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_req,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] wr_count
);

`ifdef READBACK_VERIFY_EN
    localparam bit VerifyEn = 1'b1;
`else
    localparam bit VerifyEn = 1'b0;
`endif

    localparam int unsigned PairW  = ADDR_W + DATA_W;
    localparam logic [DATA_W:0] RemOne = (DATA_W + 1)'(1);

    parse_state_e p_state_q, p_state_d;
    wr_state_e    w_state_q, w_state_d;

    logic              mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W:0]   rem_q;      // bytes left in the current burst
    logic              err_q;
    logic [ADDR_W-1:0] wr_count_q;
    logic [ADDR_W-1:0] wa_q;       // address of the write in flight
    logic [DATA_W-1:0] wd_q;       // data of the write in flight

    logic              accept;
    logic              start_ok;
    logic              push;
    logic              pop;
    logic              parse_err;
    logic              vfy_err;
    logic              wr_done;
    logic              burst_more;
    logic [DATA_W:0]   cnt_dec;

    logic [PairW-1:0]  fifo_wdata;
    logic [PairW-1:0]  fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    // ------------------------------------------------------------------
    // Pair buffer
    // ------------------------------------------------------------------
    assign fifo_wdata = {addr_q, in_word[DATA_W-1:0]};

    loader_fifo #(
        .WIDTH (PairW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Parser FSM
    // ------------------------------------------------------------------
    assign accept     = in_valid & in_ready;
    assign start_ok   = start & (p_state_q == StIdle);
    // A burst data word that is not the last byte of its burst.
    assign burst_more = (mode_q == MODE_BURST) && (rem_q != RemOne);
    // Count 0 encodes the full 2^DATA_W bytes.
    assign cnt_dec    = (in_word[DATA_W-1:0] == '0) ? {1'b1, {DATA_W{1'b0}}}
                                                    : {1'b0, in_word[DATA_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state_q <= StIdle;
        end else begin
            p_state_q <= p_state_d;
        end
    end

    always_comb begin
        p_state_d = p_state_q;
        unique case (p_state_q)
            StIdle: begin
                if (start) begin
                    p_state_d = StAddr;
                end
            end
            StAddr: begin
                if (accept) begin
                    if (in_last) begin
                        p_state_d = StDrain;
                    end else if (mode_q == MODE_BURST) begin
                        p_state_d = StCnt;
                    end else begin
                        p_state_d = StData;
                    end
                end
            end
            StCnt: begin
                if (accept) begin
                    p_state_d = in_last ? StDrain : StData;
                end
            end
            StData: begin
                if (accept) begin
                    if (in_last) begin
                        p_state_d = StDrain;
                    end else if (!burst_more) begin
                        p_state_d = StAddr;
                    end
                end
            end
            StDrain: begin
                if (done) begin
                    p_state_d = StIdle;
                end
            end
            default: p_state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (p_state_q != StIdle);
        in_ready  = busy && (p_state_q != StDrain) && !fifo_full;
        push      = accept && (p_state_q == StData);
        // in_last anywhere but on the word that closes the image truncates it.
        parse_err = accept && in_last &&
                    ((p_state_q == StAddr) || (p_state_q == StCnt) ||
                     ((p_state_q == StData) && burst_more));
        done      = (p_state_q == StDrain) && fifo_empty && (w_state_q == WIdle);
    end

    // ------------------------------------------------------------------
    // Writer FSM
    // ------------------------------------------------------------------
    assign wr_done = (w_state_q == WReq) && mem_wr_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= WIdle;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            WIdle: begin
                if (!fifo_empty) begin
                    w_state_d = WReq;
                end
            end
            WReq: begin
                if (mem_wr_ack) begin
                    if (VerifyEn) begin
                        w_state_d = WVfy;
                    end else if (fifo_empty) begin
                        w_state_d = WIdle;
                    end
                end
            end
            WVfy: begin
                if (mem_rd_ack) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        mem_wr_req = (w_state_q == WReq);
        // Back-to-back: the next pair is loaded in the same cycle as the ack.
        pop        = ((w_state_q == WIdle) && !fifo_empty) ||
                     (wr_done && !VerifyEn && !fifo_empty);
    end

`ifdef READBACK_VERIFY_EN
    assign mem_rd_req = (w_state_q == WVfy);
    assign vfy_err    = (w_state_q == WVfy) && mem_rd_ack && (mem_rdata != wd_q);
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign mem_rd_req   = 1'b0;
    assign vfy_err      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_PAIR;
            addr_q     <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            wr_count_q <= '0;
            wa_q       <= '0;
            wd_q       <= '0;
        end else begin
            if (start_ok) begin
                mode_q     <= mode;
                err_q      <= 1'b0;
                wr_count_q <= '0;
            end
            if (accept) begin
                if (p_state_q == StAddr) begin
                    addr_q <= in_word;
                end
                if (p_state_q == StCnt) begin
                    rem_q <= cnt_dec;
                end
                if ((p_state_q == StData) && (mode_q == MODE_BURST)) begin
                    addr_q <= addr_q + ADDR_W'(1);
                    rem_q  <= rem_q - RemOne;
                end
            end
            if (wr_done && (wr_count_q != '1)) begin
                wr_count_q <= wr_count_q + ADDR_W'(1);
            end
            if (parse_err || vfy_err) begin
                err_q <= 1'b1;
            end
            if (pop) begin
                wa_q <= fifo_rdata[PairW-1:DATA_W];
                wd_q <= fifo_rdata[DATA_W-1:0];
            end
        end
    end

    assign mem_addr  = wa_q;
    assign mem_wdata = wd_q;
    assign err       = err_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_mem_image_loader.sv
// Randomised self-checking bench for mem_image_loader. Images are built as word
// lists together with the list of (addr, data) writes they must produce; a memory
// model answers verify reads.
module tb_mem_image_loader;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_word = '0;
    logic          in_last = 1'b0;
    logic          mem_wr_req;
    logic          mem_wr_ack = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd_req;
    logic          mem_rd_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] wr_count;

    mem_image_loader #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .in_last    (in_last),
        .mem_wr_req (mem_wr_req),
        .mem_wr_ack (mem_wr_ack),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd_req (mem_rd_req),
        .mem_rd_ack (mem_rd_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int   ack_mode = 1;          // 0: ack low, 1: ack high, 2: random
    bit   force_rd_zero = 1'b0;  // corrupt read-back of bytes equal to 0xA0
    int   rd_req_seen = 0;
    int   words_accepted = 0;

    logic [23:0] exp_q[$];       // expected writes {addr, data} in order
    logic [16:0] img_q[$];       // image words {last, word}
    logic [7:0]  mem_model [65536];
    logic [23:0] mon_e;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory-side responder and write scoreboard. Outputs are registered, so they
    // are stable here; an ack chosen now completes at the next rising edge.
    always @(negedge clk) begin
        case (ack_mode)
            0:       mem_wr_ack = 1'b0;
            1:       mem_wr_ack = 1'b1;
            default: mem_wr_ack = ($urandom_range(0, 1) == 1);
        endcase
        if (!rst && mem_wr_req && mem_wr_ack) begin
            mem_model[mem_addr] = mem_wdata;
            check_eq("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_eq("wr_addr", 32'(mem_addr), 32'(mon_e[23:8]));
                check_eq("wr_data", 32'(mem_wdata), 32'(mon_e[7:0]));
            end
        end
        if (mem_rd_req) begin
            rd_req_seen++;
            mem_rd_ack = 1'b1;
            mem_rdata  = (force_rd_zero && mem_model[mem_addr] == 8'hA0) ? 8'h00
                                                                        : mem_model[mem_addr];
        end else begin
            mem_rd_ack = 1'b0;
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_word(input logic [16:0] wl);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_word  = wl[15:0];
        in_last  = wl[16];
        while (!ok && n < 3000) begin
            ok = in_ready;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (ok) words_accepted++;
        check_eq("in_handshake", 32'(ok), 32'd1);
    endtask

    task automatic add_pair(input logic [15:0] a, input logic [7:0] d, input bit last);
        img_q.push_back({1'b0, a});
        img_q.push_back({last, 8'h00, d});
        exp_q.push_back({a, d});
    endtask

    task automatic add_burst(input logic [15:0] base, input int count, input bit last);
        logic [7:0]  d;
        logic [15:0] a;
        img_q.push_back({1'b0, base});
        img_q.push_back({1'b0, 8'h00, 8'(count)});
        for (int i = 0; i < count; i++) begin
            d = 8'($urandom);
            a = base + 16'(i);
            img_q.push_back({(last && i == count - 1), 8'h00, d});
            exp_q.push_back({a, d});
        end
    endtask

    task automatic wait_done(input string tag, input bit exp_err, input int exp_n);
        int n;
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        check_eq({tag, "_wr_count"}, 32'(wr_count), 32'(exp_n));
        check_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_load(input logic m, input bit exp_err, input string tag,
                            input bit poke);
        int exp_n;
        exp_n = exp_q.size();
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < img_q.size(); i++) begin
            if (poke && i == 1) begin
                start = 1'b1;
                mode  = ~m;
                @(negedge clk);
                start = 1'b0;
                mode  = m;
            end
            send_word(img_q[i]);
        end
        img_q.delete();
        wait_done(tag, exp_err, exp_n);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_wr_count"}, 32'(wr_count), 32'd0);
        check_eq({tag, "_wr_req"}, 32'(mem_wr_req), 32'd0);
        check_eq({tag, "_rd_req"}, 32'(mem_rd_req), 32'd0);
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        int base_acc;
        int npairs;
        logic m;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");

        // Pair mode
        ack_mode = 1;
        add_pair(16'h0100, 8'hA0, 1'b0);
        add_pair(16'h0101, 8'h00, 1'b1);
        run_load(1'b0, 1'b0, "pair", 1'b0);

        // Burst mode
        img_q = '{17'h0001E, 17'h00002, 17'h000AA, 17'h100BB};
        exp_q = '{24'h001EAA, 24'h001FBB};
        run_load(1'b1, 1'b0, "burst", 1'b0);

        // Burst address wrap
        img_q = '{17'h0FFFF, 17'h00002, 17'h00011, 17'h10022};
        exp_q = '{24'hFFFF11, 24'h000022};
        run_load(1'b1, 1'b0, "wrap", 1'b0);

        // Count 0 means 256 bytes
        ack_mode = 2;
        add_burst(16'h1234, 256, 1'b1);
        run_load(1'b1, 1'b0, "cnt256", 1'b0);

        // Truncated images
        ack_mode = 1;
        add_pair(16'h0200, 8'h55, 1'b0);
        img_q.push_back({1'b1, 16'h0201});
        run_load(1'b0, 1'b1, "last_on_addr", 1'b0);
        img_q = '{17'h03000, 17'h10003};
        run_load(1'b1, 1'b1, "last_on_cnt", 1'b0);

        // Back-pressure: 10 pairs with the write port stalled
        ack_mode = 0;
        for (int i = 0; i < 10; i++) begin
            add_pair(16'(16'h0500 + 16'(i * 3)), 8'($urandom), i == 9);
        end
        npairs = exp_q.size();
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        base_acc = words_accepted;
        fork
            begin
                for (int i = 0; i < img_q.size(); i++) send_word(img_q[i]);
            end
            begin
                repeat (20) @(negedge clk);
                check_eq("bp_in_ready", 32'(in_ready), 32'd0);
                // One pair held at the write port plus a full buffer.
                check_eq("bp_accepted", 32'(words_accepted - base_acc), 32'(2 * (DEPTH + 1)));
                ack_mode = 1;
            end
        join
        img_q.delete();
        wait_done("bp", 1'b0, npairs);

        // Reset in the middle of a burst, with start asserted alongside reset
        ack_mode = 0;
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word({1'b0, 16'h4000});
        send_word({1'b0, 16'h0004});
        send_word({1'b0, 16'h0001});
        send_word({1'b0, 16'h0002});
        repeat (3) @(negedge clk);
        check_eq("mid_wr_req", 32'(mem_wr_req), 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clk);
        check_outputs_zero("rst_mid");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("rst_start_ignored", 32'(busy), 32'd0);
        exp_q.delete();
        ack_mode = 1;
        add_pair(16'h0600, 8'h5A, 1'b0);
        add_pair(16'h0601, 8'hC3, 1'b1);
        run_load(1'b0, 1'b0, "after_rst", 1'b0);

        // Random images with random write acks and a stray start mid-load
        ack_mode = 2;
        for (int t = 0; t < 8; t++) begin
            m = 1'($urandom_range(0, 1));
            if (m == 1'b0) begin
                npairs = $urandom_range(2, 6);
                for (int i = 0; i < npairs; i++) begin
                    add_pair(16'($urandom), 8'($urandom), i == npairs - 1);
                end
            end else begin
                npairs = $urandom_range(1, 3);
                for (int i = 0; i < npairs; i++) begin
                    add_burst(16'($urandom), $urandom_range(1, 5), i == npairs - 1);
                end
            end
            run_load(m, 1'b0, "rand", 1'b1);
        end

`ifdef READBACK_VERIFY_EN
        // Read-back mismatch on the 0xA0 byte
        ack_mode = 1;
        force_rd_zero = 1'b1;
        add_pair(16'h0100, 8'hA0, 1'b0);
        add_pair(16'h0101, 8'h00, 1'b1);
        run_load(1'b0, 1'b1, "verify", 1'b0);
        force_rd_zero = 1'b0;
        check_eq("verify_reads", 32'(rd_req_seen > 0), 32'd1);
`else
        check_eq("rd_req_idle", 32'(rd_req_seen), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
